// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM decoding opcode/funct into ALU,
// operand-select and write-enable controls, stalling on the memory ready handshake.
module mips_mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] alu_ct,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_we,
    output logic       instr_done,
    output logic       illegal
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0000;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REX,
        S_RWB, S_IEX, S_IWB, S_BEQ, S_JMP, S_ILL
    } state_t;

    state_t     state, state_nx;
    logic [5:0] funct_q;
    logic       is_sw_q;
    logic       rtype_ok;

    assign rtype_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);

    // IR fields are captured in DECODE so later states never look at a live IR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_FETCH;
            funct_q <= '0;
            is_sw_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                funct_q <= funct;
                is_sw_q <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        alu_ct     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_R:         state_nx = rtype_ok ? S_REX : S_ILL;
                    OP_ADDI:      state_nx = S_IEX;
                    OP_BEQ:       state_nx = S_BEQ;
                    OP_J:         state_nx = S_JMP;
                    default:      state_nx = S_ILL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_nx = S_FETCH;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                case (funct_q)
                    FN_SUB:  alu_ct = ALU_SUB;
                    FN_SLT:  alu_ct = ALU_SLT;
                    default: alu_ct = ALU_ADD;
                endcase
                state_nx = S_RWB;
            end
            S_RWB: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = S_IWB;
            end
            S_IWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 1'b1;
                alu_ct     = ALU_SUB;
                pc_src     = 2'b01;
                pc_en      = alu_zero;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_JMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_nx   = S_FETCH;
            end
            S_ILL: begin
                illegal  = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
        // Reset overrides everything so no write or request escapes while held.
        if (!rst) begin
            state_nx   = S_FETCH;
            alu_ct     = 4'b0000;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_we     = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: each cycle compares the full packed
// control word against a hand-written expected vector.
module tb_mips_mc_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic [3:0] alu_ct;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_en, iord, mem_req, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, instr_done, illegal;

    int n_chk = 0;
    int n_err = 0;

    mips_mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .alu_ct(alu_ct), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {alu_ct, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_req, mem_we,
                  ir_we, reg_dst, mem_to_reg, reg_we, instr_done, illegal};

    // Packs a control word in the same field order as obs.
    function automatic logic [18:0] ov(input logic [3:0] ct, input logic a, input logic [1:0] b,
                                       input logic [1:0] ps, input logic pe, input logic io,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic dn, input logic il);
        return {ct, a, b, ps, pe, io, mr, mw, irw, rd, m2r, rw, dn, il};
    endfunction

    localparam logic [18:0] V_ZERO = 19'd0;
    logic [18:0] v_fetch, v_fstall, v_dec, v_madr, v_mrd, v_mwb, v_mwr_w, v_mwr_d;
    logic [18:0] v_rex_add, v_rex_sub, v_rex_slt, v_rwb, v_iex, v_iwb, v_beq1, v_beq0, v_jmp, v_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare the current (settled) cycle, then advance to 1 time unit after the next edge.
    task automatic step(input string tag, input logic [18:0] exp);
        #1;
        chk(tag, {13'd0, obs}, {13'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        v_fetch   = ov(4'b0010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        v_fstall  = ov(4'b0010, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v_dec     = ov(4'b0010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_madr    = ov(4'b0010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_mrd     = ov(4'b0010, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        v_mwb     = ov(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        v_mwr_w   = ov(4'b0010, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        v_mwr_d   = ov(4'b0010, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        v_rex_add = ov(4'b0010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_rex_sub = ov(4'b0110, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_rex_slt = ov(4'b0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_rwb     = ov(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        v_iex     = ov(4'b0010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_iwb     = ov(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        v_beq1    = ov(4'b0110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v_beq0    = ov(4'b0110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v_jmp     = ov(4'b0010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v_ill     = ov(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        rst = 1'b0; opcode = 6'b100011; funct = 6'd0; alu_zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        step("rst_c1", V_ZERO);
        step("rst_c2", V_ZERO);
        rst = 1'b1;

        // lw, no stalls: 5 cycles
        step("lw_fetch", v_fetch);
        step("lw_dec", v_dec);
        step("lw_madr", v_madr);
        step("lw_mrd", v_mrd);
        step("lw_mwb", v_mwb);

        // R-type sub
        opcode = 6'b000000; funct = 6'b100010;
        step("sub_fetch", v_fetch);
        step("sub_dec", v_dec);
        step("sub_rex", v_rex_sub);
        step("sub_rwb", v_rwb);

        // R-type slt; IR funct changes after DECODE and must be ignored
        funct = 6'b101010;
        step("slt_fetch", v_fetch);
        step("slt_dec", v_dec);
        funct = 6'b100000;
        step("slt_rex", v_rex_slt);
        step("slt_rwb", v_rwb);

        // R-type and -> illegal
        funct = 6'b100100;
        step("and_fetch", v_fetch);
        step("and_dec", v_dec);
        step("and_ill", v_ill);

        // beq taken / not taken
        opcode = 6'b000100; alu_zero = 1'b1;
        step("beq1_fetch", v_fetch);
        step("beq1_dec", v_dec);
        step("beq1_beq", v_beq1);
        alu_zero = 1'b0;
        step("beq0_fetch", v_fetch);
        step("beq0_dec", v_dec);
        step("beq0_beq", v_beq0);

        // sw with 3 wait cycles in MEMWR: total 7; mem_ready low in DECODE is ignored
        opcode = 6'b101011;
        step("sw_fetch", v_fetch);
        mem_ready = 1'b0;
        step("sw_dec", v_dec);
        step("sw_madr", v_madr);
        step("sw_mwr_w1", v_mwr_w);
        step("sw_mwr_w2", v_mwr_w);
        step("sw_mwr_w3", v_mwr_w);
        mem_ready = 1'b1;
        step("sw_mwr_done", v_mwr_d);

        // addi
        opcode = 6'b001000;
        step("addi_fetch", v_fetch);
        step("addi_dec", v_dec);
        step("addi_iex", v_iex);
        step("addi_iwb", v_iwb);

        // j with one FETCH stall
        opcode = 6'b000010; mem_ready = 1'b0;
        step("j_fstall", v_fstall);
        mem_ready = 1'b1;
        step("j_fetch", v_fetch);
        step("j_dec", v_dec);
        step("j_jmp", v_jmp);

        // unknown opcode
        opcode = 6'b111111;
        step("bad_fetch", v_fetch);
        step("bad_dec", v_dec);
        step("bad_ill", v_ill);

        // reset asserted in REX abandons the add and restarts at FETCH
        opcode = 6'b000000; funct = 6'b100000;
        step("rr_fetch", v_fetch);
        step("rr_dec", v_dec);
        #1; chk("rr_rex_pre", {13'd0, obs}, {13'd0, v_rex_add});
        rst = 1'b0;
        step("rr_rex_rst", V_ZERO);
        rst = 1'b1;
        step("rr_restart", v_fetch);
        step("rr_dec2", v_dec);
        step("rr_rex2", v_rex_add);
        step("rr_rwb2", v_rwb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit for the MIPS datapath: a Moore state machine that decodes the instruction register opcode/funct fields and drives the ALU (`alu_ct`, operand selects) and the register, memory and PC write enables. It is the producer side of the ALU control interface: it issues the 4-bit ALU control codes and consumes `alu_zero` for branch resolution. It sits between the instruction register and the datapath muxes/enables, and stalls on a memory ready handshake.

## Interface
- none (no parameters; all encodings fixed below)

- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26], sampled in DECODE
- funct  in  6  IR[5:0], sampled in DECODE
- alu_zero  in  1  ALU zero flag, from the ALU (result == 0)
- mem_ready  in  1  memory access complete this cycle
- alu_ct  out  4  ALU control: 0010 add, 0110 sub, 0000 set-less-than
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- pc_en  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- ir_we  out  1  instruction register write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register
- reg_we  out  1  register file write
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on unsupported opcode/funct

## Operation
- Supported: R-type (opcode 000000) add 100000, sub 100010, slt 101010; lw 100011; sw 101011; beq 000100; addi 001000; j 000010. Everything else is illegal.
- States and outputs (unlisted outputs 0, alu_ct defaults to 0010):
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00; ir_we=pc_en=mem_ready. Stays until mem_ready=1, then DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next: lw/sw→MEMADR, R-type legal→REX, addi→IEX, beq→BEQ, j→JMP, else→ILL.
  - MEMADR: alu_src_a=1, alu_src_b=10. lw→MEMRD, sw→MEMWR.
  - MEMRD: mem_req=1, iord=1; wait on mem_ready, then MEMWB.
  - MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1 → FETCH.
  - MEMWR: mem_req=1, mem_we=1, iord=1; on mem_ready: instr_done=1 → FETCH.
  - REX: alu_src_a=1, alu_src_b=00, alu_ct from funct (add 0010, sub 0110, slt 0000) → RWB.
  - RWB: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1 → FETCH.
  - IEX: alu_src_a=1, alu_src_b=10, alu_ct=0010 → IWB.
  - IWB: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1 → FETCH.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_ct=0110, pc_src=01, pc_en=alu_zero, instr_done=1 → FETCH.
  - JMP: pc_src=10, pc_en=1, instr_done=1 → FETCH.
  - ILL: illegal=1, no writes → FETCH.
- R-type funct is registered in DECODE; REX must not depend on live IR contents after DECODE.

## Timing
- Outputs decode from the state register; only BEQ `pc_en` (alu_zero) and FETCH/MEMWR `ir_we`/`pc_en`/`instr_done` (mem_ready) are combinational on inputs.
- While rst=0: state loads FETCH at next edge; all outputs forced 0 (alu_ct = 0000), no memory request.
- Reset mid-instruction: abandons it, no register/memory write in the cycle after reset is sampled; restarts at FETCH.
- Latency with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3 cycles. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle; outputs held stable while waiting.
- mem_ready ignored outside FETCH, MEMRD, MEMWR.

## Test plan
- Reset: rst=0 for 2 cycles with opcode=100011 → all outputs 0; first cycle after rst=1 is FETCH with mem_req=1, alu_src_b=01.
- lw, mem_ready=1 always → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_we=1 and mem_to_reg=1 only in cycle 5; instr_done pulses once.
- R-type funct 100010, then 101010 → alu_ct=0110 then 0000 in REX; reg_dst=1 in RWB; funct 100100 (and) → illegal pulse, no reg_we.
- beq with alu_zero=1 → pc_en=1, pc_src=01 in cycle 3; repeat with alu_zero=0 → pc_en=0, instr_done still 1.
- sw with mem_ready low 3 cycles in MEMWR → mem_we/mem_req held 4 cycles, instr_done once, total latency 7.
- rst=0 asserted in REX → no reg_we in following cycle; restart at FETCH.
